// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode encoding and the
// occupancy-counter width helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // count must represent 0..depth inclusive, hence depth+1 codes
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port. Contents are never cleared, by reset or by reads.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, error pulses and a choice of
// registered-read or first-word-fall-through output.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       r_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be at least 2");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("sync_fifo: AE_LEVEL must be below AF_LEVEL");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_LEVEL must not exceed DEPTH");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Each side is qualified only by its own flag, so a read never frees room
  // for a same-cycle write at full, nor a write feed a same-cycle read at empty.
  assign wr_acc = w_en && !full_q;
  assign rd_acc = r_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end

    // Flags come from the next count so they move in step with count itself
    full_d      = (count_d == DEPTH_C);
    empty_d     = (count_d == '0);
    af_d        = (count_d >= AF_C);
    ae_d        = (count_d <= AE_C);
    overflow_d  = w_en && full_q;
    underflow_d = r_en && empty_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc && !rst),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign data_out = mem_rdata;
    assign rd_valid = !empty_q;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
      dout_d     = rd_acc ? mem_rdata : dout_q;
      rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        dout_q     <= dout_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rd_valid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench: stimulus pushes expected words, per-instance monitors pop
// and compare whenever a word is presented on data_out.
module tb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %s: got %0h ok", name, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: DEPTH=16, registered read
  logic        a_rst = 1'b1, a_w_en = 1'b0, a_r_en = 1'b0;
  logic [31:0] a_din = '0, a_dout;
  logic        a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0]  a_count;

  sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .rst(a_rst), .w_en(a_w_en), .data_in(a_din), .r_en(a_r_en),
    .data_out(a_dout), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf)
  );

  // Instance B: DEPTH=5 (non power of two), registered read
  logic       b_rst = 1'b1, b_w_en = 1'b0, b_r_en = 1'b0;
  logic [7:0] b_din = '0, b_dout;
  logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_count;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_b (
    .clk(clk), .rst(b_rst), .w_en(b_w_en), .data_in(b_din), .r_en(b_r_en),
    .data_out(b_dout), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf)
  );

  // Instance C: DEPTH=8, first-word-fall-through
  logic       c_rst = 1'b1, c_w_en = 1'b0, c_r_en = 1'b0;
  logic [7:0] c_din = '0, c_dout;
  logic       c_rd_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [3:0] c_count;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1)) u_c (
    .clk(clk), .rst(c_rst), .w_en(c_w_en), .data_in(c_din), .r_en(c_r_en),
    .data_out(c_dout), .rd_valid(c_rd_valid), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_count),
    .overflow(c_ovf), .underflow(c_unf)
  );

  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  logic [31:0] q_c [$];
  int pops_a = 0, pops_b = 0, pops_c = 0;

  always @(negedge clk) begin
    if (!a_rst && a_rd_valid) begin
      if (q_a.size() == 0) begin
        total_cnt++;
        $display("FAIL mon_a: unexpected word %0h, expected none", a_dout);
      end else begin
        chk("mon_a_data", a_dout, q_a.pop_front());
        pops_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_rd_valid) begin
      if (q_b.size() == 0) begin
        total_cnt++;
        $display("FAIL mon_b: unexpected word %0h, expected none", b_dout);
      end else begin
        chk("mon_b_data", {24'h0, b_dout}, q_b.pop_front());
        pops_b++;
      end
    end
  end

  // FWFT: a word is consumed when shown (rd_valid) and r_en is asserted
  always @(negedge clk) begin
    if (!c_rst && c_rd_valid && c_r_en) begin
      if (q_c.size() == 0) begin
        total_cnt++;
        $display("FAIL mon_c: unexpected word %0h, expected none", c_dout);
      end else begin
        chk("mon_c_data", {24'h0, c_dout}, q_c.pop_front());
        pops_c++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // Reset state
    chk("a_rst_count", 32'(a_count), 32'd0);
    chk("a_rst_empty", 32'(a_empty), 32'd1);
    chk("a_rst_full", 32'(a_full), 32'd0);
    chk("a_rst_ae", 32'(a_ae), 32'd1);
    chk("a_rst_af", 32'(a_af), 32'd0);
    chk("a_rst_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("a_rst_dout", a_dout, 32'd0);
    chk("a_rst_ovf_unf", {30'd0, a_ovf, a_unf}, 32'd0);

    // Fill 1..16
    a_w_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      a_din = 32'(i);
      q_a.push_back(32'(i));
      tick();
      if (i == 2)  chk("a_ae_at_2", 32'(a_ae), 32'd1);
      if (i == 3)  chk("a_ae_at_3", 32'(a_ae), 32'd0);
      if (i == 13) chk("a_af_at_13", 32'(a_af), 32'd0);
      if (i == 14) chk("a_af_at_14", 32'(a_af), 32'd1);
      if (i == 15) chk("a_full_at_15", 32'(a_full), 32'd0);
    end
    chk("a_full_16", 32'(a_full), 32'd1);
    chk("a_count_16", 32'(a_count), 32'd16);

    // 17th write overflows
    a_din = 32'd17;
    tick();
    chk("a_ovf_pulse", 32'(a_ovf), 32'd1);
    chk("a_count_after_ovf", 32'(a_count), 32'd16);
    a_w_en = 1'b0;
    tick();
    chk("a_ovf_clear", 32'(a_ovf), 32'd0);

    // Drain 16
    a_r_en = 1'b1;
    repeat (16) tick();
    a_r_en = 1'b0;
    tick();
    chk("a_empty_after_drain", 32'(a_empty), 32'd1);
    chk("a_count_after_drain", 32'(a_count), 32'd0);

    // Full with simultaneous read and write
    a_w_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_din = 32'(101 + i);
      q_a.push_back(32'(101 + i));
      tick();
    end
    a_r_en = 1'b1;
    a_din = 32'd999;
    tick();
    a_w_en = 1'b0; a_r_en = 1'b0;
    chk("a_full_rw_count", 32'(a_count), 32'd15);
    chk("a_full_rw_ovf", 32'(a_ovf), 32'd1);
    chk("a_full_rw_full", 32'(a_full), 32'd0);
    a_r_en = 1'b1;
    repeat (15) tick();
    a_r_en = 1'b0;
    tick();

    // Empty with simultaneous read and write
    a_w_en = 1'b1; a_r_en = 1'b1; a_din = 32'd55;
    q_a.push_back(32'd55);
    tick();
    a_w_en = 1'b0; a_r_en = 1'b0;
    chk("a_empty_rw_count", 32'(a_count), 32'd1);
    chk("a_empty_rw_unf", 32'(a_unf), 32'd1);
    chk("a_empty_rw_empty", 32'(a_empty), 32'd0);
    a_r_en = 1'b1;
    tick();
    a_r_en = 1'b0;
    tick();

    // Underflow alone leaves data_out alone
    a_r_en = 1'b1;
    tick();
    a_r_en = 1'b0;
    chk("a_unf_pulse", 32'(a_unf), 32'd1);
    chk("a_unf_dout_hold", a_dout, 32'd55);
    tick();
    chk("a_unf_clear", 32'(a_unf), 32'd0);

    // Fill to 10 then reset with w_en high
    a_w_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_din = 32'(201 + i);
      tick();
    end
    chk("a_count_10", 32'(a_count), 32'd10);
    a_rst = 1'b1; a_din = 32'hDEAD;
    tick();
    a_rst = 1'b0; a_w_en = 1'b0;
    chk("a_rst2_count", 32'(a_count), 32'd0);
    chk("a_rst2_empty", 32'(a_empty), 32'd1);
    chk("a_rst2_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("a_rst2_full", 32'(a_full), 32'd0);
    tick();
    chk("a_rst2_count_hold", 32'(a_count), 32'd0);

    // DEPTH=5: three rounds of four writes then four reads
    for (int r = 0; r < 3; r++) begin
      b_w_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
        b_din = 8'(r * 16 + i + 1);
        q_b.push_back(32'(r * 16 + i + 1));
        tick();
      end
      b_w_en = 1'b0;
      chk("b_count_4", 32'(b_count), 32'd4);
      b_r_en = 1'b1;
      repeat (4) tick();
      b_r_en = 1'b0;
      tick();
      chk("b_count_0", 32'(b_count), 32'd0);
    end

    // FWFT: written word shows before any read
    chk("c_rst_rd_valid", 32'(c_rd_valid), 32'd0);
    c_w_en = 1'b1; c_din = 8'hA5;
    q_c.push_back(32'hA5);
    tick();
    c_w_en = 1'b0;
    chk("c_fwft_valid", 32'(c_rd_valid), 32'd1);
    chk("c_fwft_dout", {24'h0, c_dout}, 32'hA5);
    c_w_en = 1'b1;
    c_din = 8'h11; q_c.push_back(32'h11); tick();
    c_din = 8'h22; q_c.push_back(32'h22); tick();
    c_w_en = 1'b0;
    c_r_en = 1'b1;
    repeat (3) tick();
    c_r_en = 1'b0;
    chk("c_empty_valid", 32'(c_rd_valid), 32'd0);
    tick();

    chk("a_pops", 32'(pops_a), 32'd33);
    chk("b_pops", 32'(pops_b), 32'd12);
    chk("c_pops", 32'(pops_c), 32'd3);
    chk("queues_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data words.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries, legal range 2..1024, any integer (not restricted to powers of 2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk input 1, sole clock, all state updates on its rising edge.
REQ-007 SHALL have port rst input 1, synchronous active-high reset.
REQ-008 SHALL have port w_en input 1, write request.
REQ-009 SHALL have port data_in input DATA_WIDTH, write data, sampled when a write is accepted.
REQ-010 SHALL have port r_en input 1, read request.
REQ-011 SHALL have port data_out output DATA_WIDTH, read data.
REQ-012 SHALL have port rd_valid output 1, data_out holds a valid popped word (FWFT=0) or a valid head word (FWFT=1).
REQ-013 SHALL have port full, empty, almost_full, almost_empty outputs 1 each, status flags.
REQ-014 SHALL have port count output $clog2(DEPTH+1), current occupancy.
REQ-015 SHALL have port overflow, underflow outputs 1 each, one-cycle error pulses.

Function
REQ-016 Write accepted iff w_en && !full; accepted word stored at wr_ptr, and wr_ptr advances.
REQ-017 Read accepted iff r_en && !empty; rd_ptr advances.
REQ-018 Acceptance of a read and a write SHALL be decided independently of each other: at full, a simultaneous write is rejected even if a read is accepted; at empty, a simultaneous read is rejected even if a write is accepted.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 by explicit compare, with no modulo on non-power-of-2 depths.
REQ-020 count next = count + accepted_write - accepted_read; both accepted leaves count unchanged.
REQ-021 full = (count == DEPTH), empty = (count == 0), both registered and derived from the next-state count, with no extra cycle of lag.
REQ-022 almost_full and almost_empty SHALL be registered and updated in the same cycle as count.
REQ-023 FWFT=0: on an accepted read, data_out is loaded with mem[rd_ptr] at that edge, and rd_valid is high for exactly the following cycle; otherwise data_out holds its value and rd_valid is 0.
REQ-024 FWFT=1: data_out = mem[rd_ptr] combinationally and rd_valid = !empty; an accepted read pops the shown word.
REQ-025 FWFT=1: a write into an empty FIFO SHALL appear on data_out the cycle after the accepting edge.
REQ-026 overflow SHALL pulse for one cycle after an edge where w_en && full; memory, pointers and count are unchanged.
REQ-027 underflow SHALL pulse for one cycle after an edge where r_en && empty; data_out is unchanged.
REQ-028 Memory contents SHALL NOT be cleared on read.

Reset
REQ-029 When rst is high at a clk edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_valid=0, data_out=0 (FWFT=0).
REQ-030 Reset SHALL take priority over simultaneous w_en/r_en; in-flight data is discarded and memory contents are not reset.

Structure
REQ-031 Package fifo_pkg SHALL hold the read-mode enum (FIFO_STD, FIFO_FWFT) and the count-width helper function.
REQ-032 Storage SHALL be a sub-module fifo_mem: a simple dual-port RAM with one write port and one asynchronous read port, parameterised by DATA_WIDTH and DEPTH.
REQ-033 Elaboration SHALL fail when DEPTH<2, AE_LEVEL>=AF_LEVEL, or AF_LEVEL>DEPTH.

Verification
REQ-034 DEPTH=16, FWFT=0: write 1..16 -> full=1 after 16th edge and count=16; 17th write -> overflow pulse, and reading 16 words returns 1..16 in order.
REQ-035 DEPTH=5: 3 rounds of write 4, read 4 -> pointers wrap at 4->0, and data order is preserved with no loss.
REQ-036 Full FIFO with w_en=r_en=1 -> read accepted, write rejected, count=DEPTH-1, overflow=1; empty FIFO with both -> write accepted, underflow=1, count=1.
REQ-037 FWFT=1: write 0xA5 to empty -> data_out=0xA5 and rd_valid=1 next cycle, before any r_en.
REQ-038 Fill to 10 (AF_LEVEL=14, AE_LEVEL=2), assert rst with w_en=1 -> next cycle count=0, empty=1, rd_valid=0, and no write recorded.
